// File: rtl/state_context_stack_pkg.sv
// Shared definitions for the FSM context save/restore path.
// Holds the state-word width and the idle/reset state encoding used by the
// controlling FSM, the legacy single-entry save unit and the context stack.
package state_context_stack_pkg;

    // Width of one FSM check-state word.
    localparam int STATE_W = 5;

    // Encoding shown when no context is saved (also the FSM reset state).
    localparam logic [STATE_W-1:0] RESET_STATE_ENC = 5'h00;

endpackage : state_context_stack_pkg

// File: rtl/state_stack_ram.sv
// DEPTH x STATE_WIDTH register array holding saved context words.
// Latency: write lands on the next rising edge; read is asynchronous (0 cycles).
// Backpressure: none, the caller decides when a write is legal.
module state_stack_ram
    import state_context_stack_pkg::*;
#(
    parameter int STATE_WIDTH = STATE_W,
    parameter int DEPTH       = 4,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [AW-1:0]          waddr_i,
    input  logic [STATE_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]          raddr_i,
    output logic [STATE_WIDTH-1:0] rdata_o
);

    // Contents are qualified by the owner's count, so no reset is needed.
    logic [STATE_WIDTH-1:0] mem_q [DEPTH];

    // Single write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read of the current top entry.
    assign rdata_o = mem_q[raddr_i];

endmodule : state_stack_ram

// File: rtl/state_context_stack.sv
// LIFO save/restore of FSM context words with full/empty status and sticky errors.
// Latency: push visible on Saved_State after 1 edge; pop result on Restore_State 1 edge later.
// Backpressure: none; push when full is dropped or overwrites oldest, pop when empty is ignored.
module state_context_stack
    import state_context_stack_pkg::*;
#(
    parameter int                   STATE_WIDTH      = STATE_W,
    parameter int                   DEPTH            = 4,
    parameter logic [STATE_WIDTH-1:0] RESET_STATE    = STATE_WIDTH'(RESET_STATE_ENC),
    parameter bit                   OVERWRITE_OLDEST = 1'b0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         Save_Enable,
    input  logic                         Restore_Enable,
    input  logic                         Clear,
    input  logic [STATE_WIDTH-1:0]       Prev_Check_State,
    output logic [STATE_WIDTH-1:0]       Saved_State,
    output logic [STATE_WIDTH-1:0]       Restore_State,
    output logic                         Restore_Valid,
    output logic [$clog2(DEPTH+1)-1:0]   Depth_Count,
    output logic                         Full,
    output logic                         Empty,
    output logic                         Overflow,
    output logic                         Underflow
);

    localparam int            CW       = $clog2(DEPTH + 1);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          top_q, top_d;
    logic [STATE_WIDTH-1:0] restore_q, restore_d;
    logic                   rvld_q, rvld_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;

    logic                   ram_we;
    logic [PW-1:0]          ram_waddr;
    logic [STATE_WIDTH-1:0] ram_rdata;
    logic [PW-1:0]          top_inc, top_dec;
    logic                   stk_full, stk_empty;

    // Storage array; the read port always follows the top pointer.
    state_stack_ram #(
        .STATE_WIDTH (STATE_WIDTH),
        .DEPTH       (DEPTH),
        .AW          (PW)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (Prev_Check_State),
        .raddr_i (top_q),
        .rdata_o (ram_rdata)
    );

    // Pointer neighbours wrap explicitly because DEPTH need not be a power of two.
    always_comb begin
        top_inc = (top_q == LAST_PTR) ? '0 : top_q + 1'b1;
        top_dec = (top_q == '0) ? LAST_PTR : top_q - 1'b1;
    end

    assign stk_full  = (count_q == FULL_CNT);
    assign stk_empty = (count_q == '0);

    // Next-state decode: Clear beats push+pop, which beats push, which beats pop.
    always_comb begin
        count_d   = count_q;
        top_d     = top_q;
        restore_d = restore_q;
        rvld_d    = 1'b0;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        ram_we    = 1'b0;
        ram_waddr = top_inc;

        if (Clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (Save_Enable && Restore_Enable) begin
            if (stk_empty) begin
                // Nothing to return: behaves as a plain push and flags the bad pop.
                ram_we  = 1'b1;
                top_d   = top_inc;
                count_d = count_q + 1'b1;
                unf_d   = 1'b1;
            end else begin
                // Swap the top entry in place; depth is unchanged even when full.
                ram_we    = 1'b1;
                ram_waddr = top_q;
                restore_d = ram_rdata;
                rvld_d    = 1'b1;
            end
        end else if (Save_Enable) begin
            if (!stk_full) begin
                ram_we  = 1'b1;
                top_d   = top_inc;
                count_d = count_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
                if (OVERWRITE_OLDEST) begin
                    // top+1 is the oldest slot when full, so the write evicts it.
                    ram_we = 1'b1;
                    top_d  = top_inc;
                end
            end
        end else if (Restore_Enable) begin
            if (!stk_empty) begin
                restore_d = ram_rdata;
                rvld_d    = 1'b1;
                count_d   = count_q - 1'b1;
                top_d     = top_dec;
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    // Control state register; reset also drops any pop result in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q   <= '0;
            top_q     <= LAST_PTR;
            restore_q <= RESET_STATE;
            rvld_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            top_q     <= top_d;
            restore_q <= restore_d;
            rvld_q    <= rvld_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Status outputs decode registered state only.
    assign Saved_State   = stk_empty ? RESET_STATE : ram_rdata;
    assign Restore_State = restore_q;
    assign Restore_Valid = rvld_q;
    assign Depth_Count   = count_q;
    assign Full          = stk_full;
    assign Empty         = stk_empty;
    assign Overflow      = ovf_q;
    assign Underflow     = unf_q;

endmodule : state_context_stack

// File: doc/state_context_stack.md
Name: state_context_stack

Overview:
Parametrised save/restore unit for FSM context: holds up to DEPTH saved state words in LIFO order, replacing the single-entry save register. Controllers push the current check state on entering a nested sequence and pop it on return. Sits beside the controlling FSM. Saved_State exposes the top entry; Restore_State returns the popped entry. Adds full/empty status, sticky error flags and a selectable full-stack policy.

Parameters:
STATE_WIDTH, 5, width of one saved state word
DEPTH, 4, number of stack entries (>=2)
RESET_STATE, 0, value shown on Saved_State/Restore_State when empty or after reset
OVERWRITE_OLDEST, 0, 1: push when full discards the oldest entry; 0: push when full is rejected

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
Save_Enable  in  1  push Prev_Check_State
Restore_Enable  in  1  pop top entry
Clear  in  1  synchronous flush of stack and sticky flags
Prev_Check_State  in  STATE_WIDTH  state word to save
Saved_State  out  STATE_WIDTH  current top entry (RESET_STATE when empty)
Restore_State  out  STATE_WIDTH  registered popped value
Restore_Valid  out  1  one-cycle pulse: Restore_State updated
Depth_Count  out  $clog2(DEPTH+1)  entries held
Full  out  1  Depth_Count == DEPTH
Empty  out  1  Depth_Count == 0
Overflow  out  1  sticky: push rejected or oldest entry dropped
Underflow  out  1  sticky: pop while empty

Behaviour:
- Reset (RST low, async): Depth_Count=0, Empty=1, Full=0, Saved_State=Restore_State=RESET_STATE, Restore_Valid=0, Overflow=Underflow=0. Stack array contents need not be reset.
- Storage: circular array of DEPTH words with top pointer, pointer wraps modulo DEPTH (DEPTH need not be a power of 2).
- Priority per edge: Clear > push+pop > push > pop.
- Clear: Depth_Count=0, flags cleared, Restore_Valid=0, Restore_State unchanged.
- Push only, not full: write entry at top+1, count+1. Saved_State shows new word in the cycle after the edge (0 extra latency beyond the register).
- Push only, full, OVERWRITE_OLDEST=1: write at top+1 over the oldest entry, count stays DEPTH, Overflow set.
- Push only, full, OVERWRITE_OLDEST=0: no write, stack unchanged, Overflow set.
- Pop only, not empty: Restore_State <= top entry, Restore_Valid=1 next cycle, count-1, top-1.
- Pop only, empty: no state change, Restore_Valid=0, Underflow set.
- Push+pop, not empty: Restore_State <= old top, Restore_Valid=1, top entry replaced by Prev_Check_State, count unchanged (valid also when full; no Overflow).
- Push+pop, empty: treated as push of Prev_Check_State plus Underflow set, Restore_Valid=0.
- Restore_Valid is 0 in every cycle not following a successful pop.
- Saved_State, Full, Empty: combinational decode of registered count/pointer/array only; no input-to-output paths.
- Sticky flags clear only by Clear or reset.
- Reset mid-operation: immediate return to reset values, in-flight pop result discarded.

Decomposition:
- Shared package: state-word width constant (5) and RESET_STATE encoding, shared with the controlling FSM and the legacy save unit.
- Sub-module: state_stack_ram (DEPTH x STATE_WIDTH register array, one write port, one async read port at top). Pointer/count/flag control stays in the top module.

Test Plan:
- Reset then push 5'h03, 5'h07, 5'h0C -> Saved_State=5'h0C, Depth_Count=3; three pops -> Restore_State 5'h0C, 5'h07, 5'h03 with Restore_Valid pulse each, then Empty=1, Saved_State=0.
- OVERWRITE_OLDEST=0, DEPTH=4: push 1,2,3,4,5 -> Full=1, Overflow=1, pops return 4,3,2,1.
- OVERWRITE_OLDEST=1, DEPTH=4: push 1..6 -> Overflow=1, pops return 6,5,4,3, then Empty.
- Push 5'h0A, then push+pop of 5'h11 in one cycle -> Restore_State=5'h0A, Restore_Valid=1, Depth_Count=1, Saved_State=5'h11.
- Pop on empty -> Underflow=1, Restore_Valid=0, count 0; then Clear -> Underflow=0.
- Push 3 words, assert RST low mid-cycle during a pop -> all outputs at reset values immediately, no Restore_Valid pulse after release.
